// File: rtl/dot_prod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_prod_pkg
// Description : Shared defaults and FSM state encoding for the dot-product
//               operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_prod_pkg;

    localparam int c_N_DEFAULT  = 1000;  // operand array depth of main
    localparam int c_AW_DEFAULT = 10;    // array address width
    localparam int c_DW_DEFAULT = 27;    // signed operand width
    localparam int c_RW_DEFAULT = 64;    // signed result width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_OUT   = 3'd6
    } state_t;

endpackage : dot_prod_pkg
`default_nettype wire

// File: rtl/dot_prod_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dot_prod_addr_ctr
// Description : Loadable up-counter producing the operand array write
//               address, with a flag marking the last array entry (N-1).
// Revision    : 1.0 - initial release
// ============================================================================
module dot_prod_addr_ctr
    import dot_prod_pkg::*;
#(
    parameter int N  = c_N_DEFAULT,
    parameter int AW = c_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    input  logic          i_inc,
    output logic [AW-1:0] o_count,
    output logic          o_at_last
);

    localparam logic [AW-1:0] c_LAST = AW'(N - 1);

    logic [AW-1:0] r_count;

    // Load takes priority over increment; the FSM never asserts both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_at_last = (r_count == c_LAST);

endmodule : dot_prod_addr_ctr
`default_nettype wire

// File: rtl/dot_prod_loader.sv
`default_nettype none
// ============================================================================
// Module      : dot_prod_loader
// Description : Streams signed (a, b) operand pairs into main's operand
//               arrays, zero-fills the unused tail, starts the computation
//               and returns the 64-bit result over a valid/ready port.
//               Optional macro DOT_PROD_LOADER_TIMEOUT_EN adds a WAIT-state
//               watchdog of TIMEOUT_CYCLES cycles reporting via out_err.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_prod_loader
    import dot_prod_pkg::*;
#(
    parameter int N              = c_N_DEFAULT,
    parameter int AW             = c_AW_DEFAULT,
    parameter int DW             = c_DW_DEFAULT,
    parameter int RW             = c_RW_DEFAULT,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [RW-1:0] out_data,
    output logic                 out_err,
    output logic                 busy,
    output logic                 controlArr,
    output logic                 controlArrWEnable_a,
    output logic                 controlArrWEnable_b,
    output logic        [AW-1:0] controlArrAddr_a,
    output logic        [AW-1:0] controlArrAddr_b,
    output logic signed [DW-1:0] controlArrWData_a,
    output logic signed [DW-1:0] controlArrWData_b,
    output logic                 r_enable,
    output logic        [AW-1:0] init_i_t_a,
    output logic        [RW-1:0] init_acc_t_a,
    input  logic                 w_enable,
    input  logic signed [RW-1:0] result
);

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_fill;
    logic                  w_ctr_load;
    logic                  w_ctr_inc;
    logic                  w_capture;
    logic                  w_tmo_hit;
    logic         [AW-1:0] w_addr;
    logic                  w_at_last;

    logic                  r_ctrl;
    logic                  r_we;
    logic         [AW-1:0] r_waddr;
    logic signed  [DW-1:0] r_wdata_a;
    logic signed  [DW-1:0] r_wdata_b;
    logic                  r_start;
    logic signed  [RW-1:0] r_out_data;

    dot_prod_addr_ctr #(
        .N  (N),
        .AW (AW)
    ) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ctr_load),
        .i_load_val ('0),
        .i_inc      (w_ctr_inc),
        .o_count    (w_addr),
        .o_at_last  (w_at_last)
    );

`ifdef DOT_PROD_LOADER_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_out_err;

    // Counts consecutive WAIT cycles without a done flag from main.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !w_enable) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo_hit = (r_state == ST_WAIT) && !w_enable &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    // Error flag is set by the watchdog and cleared by a genuine result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_err <= 1'b0;
        end else if (w_capture) begin
            r_out_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_out_err <= 1'b1;
        end
    end

    assign out_err = r_out_err;
`else
    assign w_tmo_hit = 1'b0;
    assign out_err   = 1'b0;
`endif

    // Next-state and per-cycle control decode.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_fill     = 1'b0;
        w_ctr_load = 1'b0;
        w_ctr_inc  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ctr_load = 1'b1;
                w_next     = ST_LOAD;
            end
            ST_LOAD: begin
                if (in_valid) begin
                    w_accept  = 1'b1;
                    w_ctr_inc = 1'b1;
                    // A full vector ends the load even if in_last is absent.
                    if (w_at_last) begin
                        w_next = ST_DRAIN;
                    end else if (in_last) begin
                        w_next = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                w_fill    = 1'b1;
                w_ctr_inc = 1'b1;
                if (w_at_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_enable) begin
                    w_capture = 1'b1;
                    w_next    = ST_OUT;
                end else if (w_tmo_hit) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Array port registers: each value is presented the cycle after the
    // decision, so ownership and the start pulse follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl    <= 1'b0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata_a <= '0;
            r_wdata_b <= '0;
            r_start   <= 1'b0;
        end else begin
            r_ctrl  <= (w_next inside {ST_LOAD, ST_FILL, ST_DRAIN});
            r_we    <= w_accept | w_fill;
            r_start <= (w_next == ST_START);
            if (w_accept) begin
                r_waddr   <= w_addr;
                r_wdata_a <= in_a;
                r_wdata_b <= in_b;
            end else if (w_fill) begin
                r_waddr   <= w_addr;
                r_wdata_a <= '0;
                r_wdata_b <= '0;
            end
        end
    end

    // Result register; held stable while OUT waits for out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_capture) begin
            r_out_data <= result;
        end else if (w_tmo_hit) begin
            r_out_data <= '0;
        end
    end

    assign in_ready            = (r_state == ST_LOAD);
    assign out_valid           = (r_state == ST_OUT);
    assign busy                = (r_state != ST_IDLE);
    assign out_data            = r_out_data;
    assign controlArr          = r_ctrl;
    assign controlArrWEnable_a = r_we;
    assign controlArrWEnable_b = r_we;
    assign controlArrAddr_a    = r_waddr;
    assign controlArrAddr_b    = r_waddr;
    assign controlArrWData_a   = r_wdata_a;
    assign controlArrWData_b   = r_wdata_b;
    assign r_enable            = r_start;
    assign init_i_t_a          = '0;
    assign init_acc_t_a        = '0;

endmodule : dot_prod_loader
`default_nettype wire

// File: tb/tb_dot_prod_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_prod_loader
// Description : Self-checking bench for dot_prod_loader with a behavioural
//               model of main (operand arrays plus delayed dot product).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_prod_loader;

    localparam int N  = 1000;
    localparam int AW = 10;
    localparam int DW = 27;
    localparam int RW = 64;
`ifdef DOT_PROD_LOADER_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 8192;
`endif

    typedef struct {
        int     n;
        bit     use_last;
        bit     toggle;
        int     nl;
        longint a_fill;
        longint b_fill;
        longint a_lst[4];
        longint b_lst[4];
        longint exp;
    } job_t;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_a;
    logic signed [DW-1:0] in_b;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [RW-1:0] out_data;
    logic                 out_err;
    logic                 busy;
    logic                 controlArr;
    logic                 we_a;
    logic                 we_b;
    logic        [AW-1:0] addr_a;
    logic        [AW-1:0] addr_b;
    logic signed [DW-1:0] wdata_a;
    logic signed [DW-1:0] wdata_b;
    logic                 r_enable;
    logic        [AW-1:0] init_i;
    logic        [RW-1:0] init_acc;
    logic                 w_enable;
    logic signed [RW-1:0] result;

    int total = 0;
    int bad   = 0;

    dot_prod_loader #(
        .N(N), .AW(AW), .DW(DW), .RW(RW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .busy(busy),
        .controlArr(controlArr),
        .controlArrWEnable_a(we_a), .controlArrWEnable_b(we_b),
        .controlArrAddr_a(addr_a), .controlArrAddr_b(addr_b),
        .controlArrWData_a(wdata_a), .controlArrWData_b(wdata_b),
        .r_enable(r_enable), .init_i_t_a(init_i), .init_acc_t_a(init_acc),
        .w_enable(w_enable), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model of main plus write monitor -------------------
    logic signed [DW-1:0] arr_a [N];
    logic signed [DW-1:0] arr_b [N];
    int  wcnt_a [N];
    int  wcnt_b [N];
    int  wtot_a = 0;
    int  wtot_b = 0;
    int  rcnt   = 0;
    int  rbad   = 0;
    int  lat    = 0;
    bit  hang   = 1'b0;

    initial begin
        w_enable = 1'b0;
        result   = '0;
        for (int k = 0; k < N; k++) begin
            wcnt_a[k] = 0;
            wcnt_b[k] = 0;
        end
    end

    function automatic longint dot_model();
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(arr_a[k]) * longint'(arr_b[k]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (controlArr && we_a && (int'(addr_a) < N)) begin
            arr_a[addr_a] <= wdata_a;
            wcnt_a[addr_a] = wcnt_a[addr_a] + 1;
            wtot_a = wtot_a + 1;
        end
        if (controlArr && we_b && (int'(addr_b) < N)) begin
            arr_b[addr_b] <= wdata_b;
            wcnt_b[addr_b] = wcnt_b[addr_b] + 1;
            wtot_b = wtot_b + 1;
        end
        if (r_enable) begin
            rcnt = rcnt + 1;
            if (controlArr || we_a || we_b || (init_i != '0) || (init_acc != '0)) rbad = rbad + 1;
            w_enable <= 1'b0;
            lat      <= hang ? 0 : 6;
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                w_enable <= 1'b1;
                result   <= dot_model();
            end
        end
    end

    // ---------------- helpers --------------------------------------------
    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint op_a(input job_t j, input int i);
        return (i < j.nl) ? j.a_lst[i] : j.a_fill;
    endfunction

    function automatic longint op_b(input job_t j, input int i);
        return (i < j.nl) ? j.b_lst[i] : j.b_fill;
    endfunction

    // Offers beats until max_beats have been accepted; ends on a negedge.
    task automatic feed(input job_t j, input int max_beats);
        int     i   = 0;
        int     cyc = 0;
        bit     ph  = 1'b0;
        bit     rdy;
        longint ta;
        longint tb;
        while (i < max_beats && cyc < 5000) begin
            @(negedge clk);
            ph       = ~ph;
            in_valid = j.toggle ? ph : 1'b1;
            ta       = op_a(j, i);
            tb       = op_b(j, i);
            in_a     = ta[DW-1:0];
            in_b     = tb[DW-1:0];
            in_last  = j.use_last && (i == j.n - 1);
            rdy      = in_ready;
            @(posedge clk);
            if (in_valid && rdy) i++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (i < max_beats) chk("feed beats accepted", i, max_beats);
    endtask

    task automatic run_job(input string tag, input job_t j, input int hold);
        int     base_a [N];
        int     base_b [N];
        int     bwa, bwb, brc, brb, cnt, cov, cont, unstable, rdy_bad, wsnap;
        longint got, ea, eb;
        bit     err;
        for (int k = 0; k < N; k++) begin
            base_a[k] = wcnt_a[k];
            base_b[k] = wcnt_b[k];
        end
        bwa = wtot_a; bwb = wtot_b; brc = rcnt; brb = rbad;
        feed(j, j.n);
        if (!j.use_last) chk({tag, " ready after truncation"}, in_ready, 0);
        cnt = 0;
        while (!out_valid && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, " out_valid seen"}, out_valid, 1);
        got = out_data;
        err = out_err;
        if (hold > 0) begin
            unstable = 0; rdy_bad = 0; wsnap = wtot_a;
            in_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (out_data != got || !out_valid) unstable++;
                if (in_ready) rdy_bad++;
            end
            in_valid = 1'b0;
            chk({tag, " data unstable cycles"}, unstable, 0);
            chk({tag, " in_ready during hold"}, rdy_bad, 0);
            chk({tag, " writes during hold"}, wtot_a - wsnap, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " in_ready 1 after handshake"}, in_ready, 0);
        @(negedge clk);
        chk({tag, " in_ready 2 after handshake"}, in_ready, 1);
        chk({tag, " out_data"}, got, j.exp);
        chk({tag, " out_err"}, err, 0);
        chk({tag, " writes a"}, wtot_a - bwa, N);
        chk({tag, " writes b"}, wtot_b - bwb, N);
        cov = 0; cont = 0;
        for (int k = 0; k < N; k++) begin
            if (wcnt_a[k] - base_a[k] != 1 || wcnt_b[k] - base_b[k] != 1) cov++;
            ea = (k < j.n) ? op_a(j, k) : 0;
            eb = (k < j.n) ? op_b(j, k) : 0;
            if (longint'(arr_a[k]) != ea || longint'(arr_b[k]) != eb) cont++;
        end
        chk({tag, " addresses not written once"}, cov, 0);
        chk({tag, " array content errors"}, cont, 0);
        chk({tag, " start pulses"}, rcnt - brc, 1);
        chk({tag, " bad start cycles"}, rbad - brb, 0);
    endtask

    // ---------------- test sequence --------------------------------------
    job_t jobs[6];
    job_t jr;
    job_t jp;

    initial begin
        jobs[0] = '{n:1000, use_last:1, toggle:0, nl:0, a_fill:1, b_fill:2,
                    a_lst:'{0,0,0,0}, b_lst:'{0,0,0,0}, exp:2000};
        jobs[1] = '{n:3, use_last:1, toggle:0, nl:3, a_fill:0, b_fill:0,
                    a_lst:'{3,-5,7,0}, b_lst:'{4,6,-8,0}, exp:-74};
        jobs[2] = '{n:1000, use_last:1, toggle:1, nl:0, a_fill:-67108864, b_fill:-67108864,
                    a_lst:'{0,0,0,0}, b_lst:'{0,0,0,0}, exp:64'sd4503599627370496000};
        jobs[3] = '{n:1, use_last:1, toggle:0, nl:1, a_fill:0, b_fill:0,
                    a_lst:'{7,0,0,0}, b_lst:'{-3,0,0,0}, exp:-21};
        jobs[4] = '{n:1000, use_last:0, toggle:0, nl:0, a_fill:3, b_fill:-1,
                    a_lst:'{0,0,0,0}, b_lst:'{0,0,0,0}, exp:-3000};
        jobs[5] = '{n:999, use_last:1, toggle:0, nl:0, a_fill:-1, b_fill:-1,
                    a_lst:'{0,0,0,0}, b_lst:'{0,0,0,0}, exp:999};
        jr = '{n:1000, use_last:0, toggle:0, nl:0, a_fill:9, b_fill:9,
               a_lst:'{0,0,0,0}, b_lst:'{0,0,0,0}, exp:0};
        jp = '{n:2, use_last:1, toggle:0, nl:2, a_fill:0, b_fill:0,
               a_lst:'{5,1,0,0}, b_lst:'{5,1,0,0}, exp:26};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset control outputs",
            {in_ready, out_valid, out_err, busy, controlArr, we_a, we_b, r_enable}, 0);
        chk("reset data outputs",
            (|out_data) | (|addr_a) | (|addr_b) | (|wdata_a) | (|wdata_b) | (|init_i) | (|init_acc), 0);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_job($sformatf("job%0d", t), jobs[t], (t == 1) ? 20 : 0);
        end

        // Reset in the middle of a load: nothing may start, outputs clear at once.
        begin
            int brc;
            brc = rcnt;
            feed(jr, 500);
            #2 rst = 1'b1;
            #1;
            chk("midjob reset control",
                {in_ready, out_valid, out_err, busy, controlArr, we_a, we_b, r_enable}, 0);
            chk("midjob reset data",
                (|out_data) | (|addr_a) | (|wdata_a) | (|wdata_b), 0);
            @(negedge clk);
            rst = 1'b0;
            chk("midjob no start", rcnt - brc, 0);
            run_job("after reset", jp, 0);
        end

`ifdef DOT_PROD_LOADER_TIMEOUT_EN
        begin
            int cnt;
            int nwait;
            hang = 1'b1;
            feed(jobs[3], 1);
            cnt = 0;
            while (!r_enable && cnt < 2000) begin
                @(negedge clk);
                cnt++;
            end
            chk("tmo start seen", r_enable, 1);
            nwait = 0;
            cnt   = 0;
            @(negedge clk);
            while (!out_valid && cnt < 100) begin
                nwait++;
                cnt++;
                @(negedge clk);
            end
            chk("tmo wait cycles", nwait, TMO);
            chk("tmo out_err", out_err, 1);
            chk("tmo out_data", out_data, 0);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            hang = 1'b0;
            repeat (10) @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "bench watchdog expired");
    end

endmodule : tb_dot_prod_loader
`default_nettype wire

// File: doc/dot_prod_loader.md
# dot_prod_loader

Host-side front end for the dot-product datapath `main`. Accepts a stream of signed `(a, b)` operand pairs over valid/ready and writes them into `main`'s two operand arrays through its `controlArr` write ports, zero-filling unused entries. It then pulses `r_enable` to start the computation, waits for `w_enable`, and returns the 64-bit result on a valid/ready output port. Sits directly upstream of `main` and drives every one of its inputs.

## Interface
- `N`, 1000: array depth; must equal `main`'s array size.
- `AW`, 10: address / index width.
- `DW`, 27: signed operand width.
- `RW`, 64: signed result and accumulator width.
- `TIMEOUT_CYCLES`, 8192: watchdog limit. Used only with `DOT_PROD_LOADER_TIMEOUT_EN`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid` / `in_ready`  in / out  1 / 1  operand stream handshake.
- `in_a`, `in_b`  in  DW  signed operands.
- `in_last`  in  1  marks the final pair of a vector.
- `out_valid` / `out_ready`  out / in  1 / 1  result handshake.
- `out_data`  out  RW  signed dot product.
- `out_err`  out  1  timeout flag; qualified by `out_valid`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `controlArr`  out  1  gives array ownership to the loader.
- `controlArrWEnable_a` / `_b`  out  1  array write strobes.
- `controlArrAddr_a` / `_b`  out  AW  array write addresses.
- `controlArrWData_a` / `_b`  out  DW  array write data.
- `r_enable`  out  1  start pulse to `main`.
- `init_i_t_a`  out  AW  start index; always 0.
- `init_acc_t_a`  out  RW  initial accumulator; always 0.
- `w_enable`  in  1  done flag from `main`.
- `result`  in  RW  result from `main`.

## Operation
- **States:** IDLE, LOAD, FILL, DRAIN, START, WAIT, OUT.
- **IDLE**
  - Go to LOAD on the next edge. `in_ready` = 0.
  - Address counter `addr` is cleared to 0.
- **LOAD**
  - `in_ready` = 1, decoded from state.
  - Each accepted beat registers `controlArr`=1, both write strobes=1, both addresses=`addr`, and write data `in_a`/`in_b`. Then `addr`++.
  - Accepted beat with `in_last`=1 and `addr` < N-1: go to FILL.
  - Accepted beat with `addr` == N-1: go to DRAIN. `in_last` is ignored on this beat; the vector is truncated to N.
  - No accepted beat: write strobes drop to 0 and `controlArr` stays 1.
- **FILL**
  - Writes 0 to both arrays at `addr`..N-1, one entry per cycle.
  - After the write at N-1, go to DRAIN.
- **DRAIN**
  - Exactly 1 cycle: strobes=0, `controlArr`=1. This lets the last registered write land.
- **START**
  - Exactly 1 cycle: `controlArr`=0, `r_enable`=1, `init_i_t_a`=0, `init_acc_t_a`=0.
- **WAIT**
  - `r_enable`=0. `w_enable` is sampled only in this state; before the first start it is undefined.
  - When `w_enable`=1: capture `result` into `out_data`, set `out_err`=0, go to OUT.
- **OUT**
  - `out_valid`=1. `out_data` and `out_err` are held stable until `out_ready`=1.
  - Handshake completes: go to IDLE.
- **Arithmetic:** no arithmetic in this block. Data is passed through unmodified; sign is preserved because the data ports are declared signed.
- **Reset**
  - Outputs: all outputs 0.
  - State and counters: FSM=IDLE, `addr`=0, timeout counter=0.
- **Reset mid-job:** the job is discarded and a partial vector is never started. `main` is left stale; the next job reloads every entry and re-pulses `r_enable`.

## Timing
- **Write latency:** a beat accepted at edge k is presented on the array ports during cycle k+1 and written at edge k+1.
- **Load throughput:** 1 pair/cycle with no backpressure.
- **Job latency:** N cycles of LOAD+FILL, +1 DRAIN, +1 START, + `main`'s compute time, +1 capture.
- **Start to done:** the edge carrying `r_enable`=1 clears `w_enable`, so the first WAIT cycle always sees `w_enable`=0.
- **Output hold:** `out_valid` is asserted the cycle after `w_enable` is seen.
- **Back-to-back jobs:** after the OUT handshake, `in_ready` returns 2 cycles later (OUT→IDLE→LOAD).
- **Simultaneous events:** `in_valid`=0 while `in_last` is pending has no effect; `in_last` is honoured only on an accepted beat.

## Configuration
- **`DOT_PROD_LOADER_TIMEOUT_EN` defined**
  - A counter runs in WAIT.
  - If `w_enable` is still 0 after `TIMEOUT_CYCLES` WAIT cycles: go to OUT with `out_data`=0 and `out_err`=1.
- **Undefined**
  - WAIT lasts indefinitely.
  - `out_err` is tied to 0 and no counter is built.

## Structure
- **Package `dot_prod_pkg`:** default constants for `N`, `AW`, `DW`, `RW`, and the FSM state typedef.
- **Sub-module `dot_prod_addr_ctr`:**
  - A loadable `AW`-bit up-counter shared by LOAD and FILL.
  - Provides an `at_last` (== N-1) flag.
- **FSM, write registers and output register:** stay in the top module.

## Test plan
- 1000 pairs `a`=1, `b`=2, no backpressure → `out_data`=2000, `out_err`=0, exactly 1000 write strobes per array.
- 3 pairs (3,4), (-5,6), (7,-8), `in_last` on the third → addresses 3..999 written with 0; `out_data`=-74.
- 1000 pairs `a`=`b`=-2^26 with `in_valid` toggled every cycle → `out_data`=4503599627370496000, no dropped or duplicated beats.
- `out_ready` held 0 for 20 cycles after `out_valid` → `out_data` stable, `in_ready`=0; a new job is accepted only after the handshake.
- `rst` pulsed after 500 beats → all outputs 0 asynchronously. A following 2-pair job (5,5),(1,1) gives 26.
- With the macro, `TIMEOUT_CYCLES`=16 and a stub holding `w_enable`=0 → `out_valid` after 16 WAIT cycles with `out_err`=1 and `out_data`=0.
